mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit between the E_M pipeline register and the M_W_reg. It turns the memory-stage control and ALU address into a word-aligned request on a valid/ready data bus, waits a variable number of cycles for the response, and formats load data (byte/half/word, signed/unsigned) into `M_mem_data`. While an access is in flight it raises `M_stall` so the hazard unit freezes the front of the pipeline and holds M.

## Interface
- `DATA_WIDTH`, 32, data and address width; byte-lane logic is fixed at 4 lanes, so only 32 is supported.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `M_MemRead`  in  1  load in M.
- `M_MemWrite`  in  1  store in M.
- `M_funct3`  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `M_alu_result`  in  DATA_WIDTH  effective byte address.
- `M_write_data`  in  DATA_WIDTH  store data, rs2 value, right-aligned.
- `M_mem_data`  out  DATA_WIDTH  formatted load data to M_W_reg (registered).
- `M_stall`  out  1  hold pipeline stages up to and including M (combinational).
- `M_access_fault`  out  1  illegal or misaligned access in M (combinational).
- `dbus_valid`  out  1  request valid (registered).
- `dbus_we`  out  1  1 = write (registered).
- `dbus_addr`  out  DATA_WIDTH  word address, {addr[31:2],2'b00} (registered).
- `dbus_wdata`  out  DATA_WIDTH  lane-replicated store data (registered).
- `dbus_wstrb`  out  4  byte enables; 0 for reads (registered).
- `dbus_ready`  in  1  request accepted when high with `dbus_valid`.
- `dbus_rvalid`  in  1  read data valid.
- `dbus_rdata`  in  DATA_WIDTH  read word.

## Operation
- Access = `M_MemRead | M_MemWrite`.
- Fault when any of the following holds. On a fault, no bus request is issued and `M_stall` stays 0.
  - Both `M_MemRead` and `M_MemWrite` are high.
  - `M_funct3` is in {011, 110, 111}, or is 100/101 on a store.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 0.
- FSM states IDLE, REQ, RESP, DONE:
  - IDLE: on a legal access, latch the bus fields and go to REQ. Otherwise stay in IDLE.
  - REQ: `dbus_valid` = 1. On `dbus_ready`, a write goes to DONE and a read goes to RESP. Otherwise hold REQ with all bus fields stable.
  - RESP: on `dbus_rvalid`, register the formatted load into `M_mem_data` and go to DONE.
  - DONE: always go to IDLE.
- `M_stall` = (IDLE & legal access) | REQ | RESP. It is 0 in DONE, so the completed instruction advances into M_W_reg on that edge and a new instruction enters M. That new instruction is only evaluated in the following IDLE cycle, so an access is never re-issued.
- Store lanes:
  - SB: wdata = {4{wd[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{wd[15:0]}}, wstrb = 0011 << addr[1:0].
  - SW: wdata = wd, wstrb = 1111.
- Load formatting: select byte lane addr[1:0] (LB/LBU) or halfword lane addr[1] (LH/LHU). LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- `M_mem_data` changes only on `dbus_rvalid` in RESP. It otherwise holds its value, including across stores and non-memory instructions.
- `dbus_rvalid` outside RESP and `dbus_ready` outside REQ are ignored.

## Timing
- Reset, asynchronous: state = IDLE and all registered outputs = 0. While `rst` is high, `M_stall` and `M_access_fault` are forced to 0. A reset mid-access abandons the transaction and `dbus_valid` drops immediately.
- Store with `dbus_ready` high in the first REQ cycle: stall cycles IDLE and REQ (2), instruction advances on the DONE edge.
- Load with ready in the first REQ cycle and rvalid in the first RESP cycle: 3 stall cycles, data visible in DONE.
- Each wait cycle on ready or rvalid adds exactly one stall cycle.
- A load's data is valid in M_W_reg the cycle after DONE.
- Back-to-back accesses: DONE is followed by IDLE, which issues the next access. Minimum spacing is 4 cycles for loads and 3 for stores.

## Test plan
- LW at 0x100, ready in the first REQ cycle, rdata = 0xDEADBEEF on the next cycle → `dbus_addr` = 0x100, wstrb = 0, stall high for exactly 3 cycles, `M_mem_data` = 0xDEADBEEF in DONE.
- LB at 0x103 with rdata 0x80FF_0000, then LBU at the same address → `M_mem_data` = 0xFFFFFF80, then 0x00000080. LH at 0x102 with rdata 0x8001_0000 → 0xFFFF8001.
- SB at 0x201 with wd = 0x12345678, ready held low 3 cycles → `dbus_valid`, addr 0x200, wdata 0x78787878, wstrb 0010 all stable through the wait, stall high for 5 cycles.
- LW at 0x102, or SH at 0x101, or funct3 = 011 → `M_access_fault` = 1 in the same cycle, `dbus_valid` never asserts, stall stays 0.
- `rst` pulsed while in RESP → `dbus_valid` = 0, stall = 0, `M_mem_data` = 0 immediately. A subsequent late `dbus_rvalid` is ignored.
- Two consecutive LW instructions, the second a non-memory op in between, with random ready/rvalid delays → each load issued exactly once, correct data per load, `M_mem_data` unchanged by the non-memory op.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one word-aligned valid/ready bus request
// per legal access, stalls the pipeline while it is in flight, and formats load data.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  M_MemRead,
    input  logic                  M_MemWrite,
    input  logic [2:0]            M_funct3,
    input  logic [DATA_WIDTH-1:0] M_alu_result,
    input  logic [DATA_WIDTH-1:0] M_write_data,
    output logic [DATA_WIDTH-1:0] M_mem_data,
    output logic                  M_stall,
    output logic                  M_access_fault,
    output logic                  dbus_valid,
    output logic                  dbus_we,
    output logic [DATA_WIDTH-1:0] dbus_addr,
    output logic [DATA_WIDTH-1:0] dbus_wdata,
    output logic [3:0]            dbus_wstrb,
    input  logic                  dbus_ready,
    input  logic                  dbus_rvalid,
    input  logic [DATA_WIDTH-1:0] dbus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t                state_reg, state_next;
    logic [2:0]            funct3_reg;
    logic [1:0]            lane_reg;
    logic                  access, fault_raw, legal;
    logic                  bad_funct3, misaligned;
    logic [DATA_WIDTH-1:0] store_wdata;
    logic [3:0]            store_wstrb;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign access     = M_MemRead | M_MemWrite;
    assign bad_funct3 = (M_funct3 == 3'b011) || (M_funct3 == 3'b110) || (M_funct3 == 3'b111)
                        || (M_MemWrite && M_funct3[2]);
    assign misaligned = ((M_funct3[1:0] == 2'b01) && M_alu_result[0])
                        || ((M_funct3[1:0] == 2'b10) && (M_alu_result[1:0] != 2'b00));
    assign fault_raw  = access && ((M_MemRead && M_MemWrite) || bad_funct3 || misaligned);
    assign legal      = access && !fault_raw;

    // Both combinational outputs are forced low while reset is held.
    assign M_access_fault = !rst && fault_raw;
    assign M_stall        = !rst && (((state_reg == IDLE) && legal)
                                     || (state_reg == REQ) || (state_reg == RESP));

    always_comb begin
        store_wdata = M_write_data;
        store_wstrb = 4'b1111;
        case (M_funct3[1:0])
            2'b00: begin
                store_wdata = {4{M_write_data[7:0]}};
                store_wstrb = 4'b0001 << M_alu_result[1:0];
            end
            2'b01: begin
                store_wdata = {2{M_write_data[15:0]}};
                store_wstrb = 4'b0011 << M_alu_result[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte   = dbus_rdata[{lane_reg, 3'b000} +: 8];
        ld_half   = lane_reg[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        load_data = dbus_rdata;
        case (funct3_reg)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (legal) state_next = REQ;
            REQ:     if (dbus_ready) state_next = dbus_we ? DONE : RESP;
            RESP:    if (dbus_rvalid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            funct3_reg <= 3'b000;
            lane_reg   <= 2'b00;
            M_mem_data <= '0;
            dbus_valid <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            dbus_wstrb <= 4'b0000;
        end else begin
            state_reg  <= state_next;
            dbus_valid <= (state_next == REQ);
            // Bus fields are captured once and stay frozen until the next access.
            if ((state_reg == IDLE) && legal) begin
                funct3_reg <= M_funct3;
                lane_reg   <= M_alu_result[1:0];
                dbus_we    <= M_MemWrite;
                dbus_addr  <= {M_alu_result[DATA_WIDTH-1:2], 2'b00};
                dbus_wdata <= store_wdata;
                dbus_wstrb <= M_MemWrite ? store_wstrb : 4'b0000;
            end
            if ((state_reg == RESP) && dbus_rvalid)
                M_mem_data <= load_data;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit with a load-data scoreboard.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        M_MemRead, M_MemWrite;
    logic [2:0]  M_funct3;
    logic [31:0] M_alu_result, M_write_data, M_mem_data;
    logic        M_stall, M_access_fault;
    logic        dbus_valid, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_ready, dbus_rvalid;
    logic [31:0] dbus_rdata;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_data;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_funct3(M_funct3),
        .M_alu_result(M_alu_result), .M_write_data(M_write_data),
        .M_mem_data(M_mem_data), .M_stall(M_stall), .M_access_fault(M_access_fault),
        .dbus_valid(dbus_valid), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_ready(dbus_ready), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * int'(a));
        case (f3)
            3'b000:  return 32'($signed(sh[7:0]));
            3'b001:  return 32'($signed(sh[15:0]));
            3'b100:  return 32'(sh[7:0]);
            3'b101:  return 32'(sh[15:0]);
            default: return w;
        endcase
    endfunction

    // Entered on a falling edge; returns on the falling edge of the IDLE cycle after DONE.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input logic [31:0] exp_data,
                          input int rdly, input int vdly);
        int          stall_cnt = 0, waited = 0, vwait = 0, issued = 0, phase = 0;
        bit          done = 0;
        logic [31:0] exp_wdata, got;
        logic [3:0]  exp_wstrb;
        case (f3[1:0])
            2'b00:   begin exp_wdata = {4{wd[7:0]}};  exp_wstrb = 4'b0001 << addr[1:0]; end
            2'b01:   begin exp_wdata = {2{wd[15:0]}}; exp_wstrb = 4'b0011 << addr[1:0]; end
            default: begin exp_wdata = wd;            exp_wstrb = 4'b1111;              end
        endcase
        if (rd) exp_wstrb = 4'b0000;
        M_MemRead = rd; M_MemWrite = wr; M_funct3 = f3;
        M_alu_result = addr; M_write_data = wd;
        dbus_ready = 1'b0; dbus_rvalid = 1'b0;
        if (rd) exp_q.push_back(exp_data);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (cyc == 0) check("no_fault", {31'd0, M_access_fault}, 32'd0);
            if (stall_cnt > 0 && !M_stall) begin
                done = 1;
                check("stall_cycles", stall_cnt, rd ? 3 + rdly + vdly : 2 + rdly);
                check("issue_count", issued, 1);
                if (rd) begin
                    got = exp_q.pop_front();
                    check("load_data", M_mem_data, got);
                    last_data = got;
                end else begin
                    check("data_hold_store", M_mem_data, last_data);
                end
                M_MemRead = 1'b0; M_MemWrite = 1'b0;
                dbus_ready = 1'b0; dbus_rvalid = 1'b0;
            end else begin
                if (M_stall) stall_cnt++;
                if (phase == 2) begin
                    dbus_rvalid = (vwait >= vdly);
                    dbus_rdata  = dbus_rvalid ? rdata : $urandom;
                    if (dbus_rvalid) phase = 3;
                    vwait++;
                end else begin
                    dbus_rvalid = 1'b0;
                end
                if (dbus_valid) begin
                    check("bus_addr", dbus_addr, {addr[31:2], 2'b00});
                    check("bus_we_wstrb", {27'd0, dbus_we, dbus_wstrb}, {27'd0, wr, exp_wstrb});
                    if (wr) check("bus_wdata", dbus_wdata, exp_wdata);
                    dbus_ready = (waited >= rdly);
                    if (dbus_ready) begin
                        issued++;
                        if (rd) phase = 2;
                    end
                    waited++;
                end else begin
                    dbus_ready = 1'b0;
                end
            end
            @(negedge clk);
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
    endtask

    task automatic fault_case(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr);
        M_MemRead = rd; M_MemWrite = wr; M_funct3 = f3; M_alu_result = addr;
        #1;
        check({tag, "_fault"}, {31'd0, M_access_fault}, 32'd1);
        check({tag, "_stall"}, {31'd0, M_stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check({tag, "_no_valid"}, {31'd0, dbus_valid | M_stall}, 32'd0);
        end
        M_MemRead = 1'b0; M_MemWrite = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [2:0]  f3;
        rst = 1'b1;
        M_MemRead = 1'b1; M_MemWrite = 1'b0; M_funct3 = 3'b010;
        M_alu_result = 32'h100; M_write_data = 32'h0;
        dbus_ready = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
        last_data = 32'h0;
        #12;
        check("rst_stall_forced", {31'd0, M_stall}, 32'd0);
        check("rst_valid", {31'd0, dbus_valid}, 32'd0);
        check("rst_mem_data", M_mem_data, 32'd0);
        check("rst_wstrb_addr", {dbus_wstrb, dbus_addr[27:0]}, 32'd0);
        M_MemRead = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        access(1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 32'hFFFFFF80, 0, 0);
        access(1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 32'h00000080, 1, 2);
        access(1, 0, 3'b001, 32'h102, 0, 32'h80010000, 32'hFFFF8001, 2, 1);
        access(0, 1, 3'b000, 32'h201, 32'h12345678, 0, 0, 3, 0);
        access(0, 1, 3'b001, 32'h102, 32'hABCD1234, 0, 0, 1, 0);
        access(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 0, 0, 0);

        fault_case("lw_misaligned", 1, 0, 3'b010, 32'h102);
        fault_case("sh_misaligned", 0, 1, 3'b001, 32'h101);
        fault_case("funct3_011", 1, 0, 3'b011, 32'h100);
        fault_case("store_unsigned", 0, 1, 3'b100, 32'h100);
        fault_case("rd_and_wr", 1, 1, 3'b010, 32'h100);

        // Reset while waiting in RESP, then a late rvalid must be ignored.
        M_MemRead = 1'b1; M_funct3 = 3'b010; M_alu_result = 32'h400;
        #1; check("rr_idle_stall", {31'd0, M_stall}, 32'd1);
        @(negedge clk); #1;
        check("rr_req_valid", {31'd0, dbus_valid}, 32'd1);
        dbus_ready = 1'b1;
        @(negedge clk); #1;
        dbus_ready = 1'b0;
        check("rr_resp_stall", {31'd0, M_stall}, 32'd1);
        rst = 1'b1; #1;
        check("rr_valid", {31'd0, dbus_valid}, 32'd0);
        check("rr_stall", {31'd0, M_stall}, 32'd0);
        check("rr_mem_data", M_mem_data, 32'd0);
        M_MemRead = 1'b0;
        @(negedge clk); rst = 1'b0;
        dbus_rvalid = 1'b1; dbus_rdata = 32'h5555AAAA;
        @(negedge clk); dbus_rvalid = 1'b0; #1;
        check("rr_late_rvalid", M_mem_data, 32'd0);
        check("rr_late_state", {30'd0, dbus_valid, M_stall}, 32'd0);
        last_data = 32'h0;
        @(negedge clk);

        // Random loads separated by non-memory cycles.
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            case ($urandom_range(0, 4))
                0:       f3 = 3'b000;
                1:       f3 = 3'b001;
                2:       f3 = 3'b100;
                3:       f3 = 3'b101;
                default: f3 = 3'b010;
            endcase
            a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if (f3 == 3'b000 || f3 == 3'b100) a[1:0] = 2'($urandom_range(0, 3));
            if (f3 == 3'b001 || f3 == 3'b101) a[1] = 1'($urandom_range(0, 1));
            access(1, 0, f3, a, 0, d, fmt_load(f3, a[1:0], d),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            dbus_rvalid = 1'b1; dbus_rdata = ~d;
            @(negedge clk); #1;
            dbus_rvalid = 1'b0;
            check("nonmem_hold", M_mem_data, last_data);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
